// File: rtl/csr_read_pipe_pkg.sv
// Shared definitions for the read-only counter CSR pipeline: the counter
// addresses, the SYSTEM opcode, the counter-select encoding and the ID/EX
// register layout.
package csr_read_pipe_pkg;

  localparam logic [6:0]  OPCODE_SYSTEM = 7'b1110011;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = CSR_CYCLE   + 12'h080;
  localparam logic [11:0] CSR_TIMEH    = CSR_TIME    + 12'h080;
  localparam logic [11:0] CSR_INSTRETH = CSR_INSTRET + 12'h080;

  // Counter-unit select; time is an alias of cycle so it shares its codes.
  typedef enum logic [1:0] {
    SEL_CYCLE_LO   = 2'd0,
    SEL_CYCLE_HI   = 2'd1,
    SEL_INSTRET_LO = 2'd2,
    SEL_INSTRET_HI = 2'd3
  } csr_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } ill_state_e;

  // ID/EX pipeline register contents.
  typedef struct packed {
    logic       valid;
    csr_sel_e   sel;
    logic [4:0] rd;
    logic       illegal;
  } id_ex_t;

endpackage

// File: rtl/csr_read_pipe_if.sv
// Bundle of pipeline-side signals around the counter CSR read stage.
// slave is the stage itself; master is whatever surrounds it.
interface csr_read_pipe_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      stall_i;
  logic                      flush_ID_EX_i;
  logic                      id_valid_i;
  logic [31:0]               id_instr_i;
  logic [DATA_WIDTH-1:0]     CSR_OUT_i;
  logic                      trap_ack_i;
  logic [1:0]                CSRSel_o;
  logic                      ex_csr_valid_o;
  logic                      csr_illegal_o;
  logic                      wb_valid_o;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_o;
  logic [DATA_WIDTH-1:0]     wb_data_o;

  modport slave (
    input  stall_i, flush_ID_EX_i, id_valid_i, id_instr_i, CSR_OUT_i, trap_ack_i,
    output CSRSel_o, ex_csr_valid_o, csr_illegal_o, wb_valid_o, wb_rd_o, wb_data_o
  );

  modport master (
    output stall_i, flush_ID_EX_i, id_valid_i, id_instr_i, CSR_OUT_i, trap_ack_i,
    input  CSRSel_o, ex_csr_valid_o, csr_illegal_o, wb_valid_o, wb_rd_o, wb_data_o
  );
endinterface

// File: rtl/csr_read_pipe_addr_decode.sv
// Combinational decode of an instruction word into counter-CSR attributes.
// Kept standalone so the hazard unit can reuse the same classification.
module csr_addr_decode
  import csr_read_pipe_pkg::*;
#(
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic [31:0] instr_i,
  output logic        is_csr_o,
  output logic        read_only_o,
  output logic        legal_o,
  output csr_sel_e    sel_o,
  output logic [4:0]  rd_o
);

  logic [6:0]                opcode;
  logic [2:0]                funct3;
  logic [4:0]                rs1;
  logic [CSR_ADDR_WIDTH-1:0] addr;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign addr   = instr_i[31 -: CSR_ADDR_WIDTH];
  assign rd_o   = instr_i[11:7];

  // Classify the access and map the address onto a counter select.
  always_comb begin
    logic mapped;
    mapped      = 1'b1;
    sel_o       = SEL_CYCLE_LO;
    // funct3 000 is ECALL/EBREAK/xRET, not a CSR access.
    is_csr_o    = (opcode == OPCODE_SYSTEM) && (funct3 != 3'b000);
    // Only CSRRS/CSRRC(I) with a zero source field leave the CSR untouched.
    read_only_o = is_csr_o && (funct3[1] == 1'b1) && (rs1 == 5'd0);
    case (addr)
      CSR_CYCLE, CSR_TIME:   sel_o = SEL_CYCLE_LO;
      CSR_CYCLEH, CSR_TIMEH: sel_o = SEL_CYCLE_HI;
      CSR_INSTRET:           sel_o = SEL_INSTRET_LO;
      CSR_INSTRETH:          sel_o = SEL_INSTRET_HI;
      default:               mapped = 1'b0;
    endcase
    legal_o = is_csr_o && mapped && read_only_o;
  end

endmodule

// File: rtl/csr_read_pipe.sv
// ID/EX and EX/MEM stage for the read-only counter CSRs, with a sticky
// illegal-access trap request held until the trap unit acknowledges it.
module csr_read_pipe
  import csr_read_pipe_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  csr_read_pipe_if.slave  bus
);

  logic       dec_is_csr;
  logic       dec_read_only;
  logic       dec_legal;
  csr_sel_e   dec_sel;
  logic [4:0] dec_rd;
  logic       ld_read;
  logic       ld_illegal;

  id_ex_t     id_ex_reg;
  id_ex_t     id_ex_next;

  logic                      wb_valid_reg;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_reg;
  logic [DATA_WIDTH-1:0]     wb_data_reg;

  ill_state_e state_reg;
  ill_state_e state_next;
  logic       ill_take;

  csr_addr_decode #(
    .CSR_ADDR_WIDTH (CSR_ADDR_WIDTH)
  ) u_decode (
    .instr_i     (bus.id_instr_i),
    .is_csr_o    (dec_is_csr),
    .read_only_o (dec_read_only),
    .legal_o     (dec_legal),
    .sel_o       (dec_sel),
    .rd_o        (dec_rd)
  );

  assign ld_read    = bus.id_valid_i && dec_is_csr && dec_read_only && dec_legal;
  assign ld_illegal = bus.id_valid_i && dec_is_csr && !dec_legal;

  // ID/EX next value: flush beats stall; sel/rd only move with a legal read.
  always_comb begin
    id_ex_next = id_ex_reg;
    if (bus.flush_ID_EX_i) begin
      id_ex_next.valid   = 1'b0;
      id_ex_next.illegal = 1'b0;
    end else if (!bus.stall_i) begin
      id_ex_next.valid   = ld_read;
      id_ex_next.illegal = ld_illegal;
      if (ld_read) begin
        id_ex_next.sel = dec_sel;
        id_ex_next.rd  = dec_rd;
      end
    end
  end

  // ID/EX register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      id_ex_reg <= '0;
    end else begin
      id_ex_reg <= id_ex_next;
    end
  end

  // EX/MEM register: samples the counter on the last (unstalled) EX cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wb_valid_reg <= 1'b0;
      wb_rd_reg    <= '0;
      wb_data_reg  <= '0;
    end else if (!bus.stall_i) begin
      wb_valid_reg <= id_ex_reg.valid && (id_ex_reg.rd != 5'd0);
      wb_rd_reg    <= id_ex_reg.rd;
      wb_data_reg  <= bus.CSR_OUT_i;
    end
  end

  // An illegal instruction is taken when it leaves EX.
  assign ill_take = id_ex_reg.illegal && !bus.stall_i;

  // Trap request state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Trap request next state; a new take in the ack cycle keeps it pending.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (ill_take) state_next = ST_PEND;
      ST_PEND: if (bus.trap_ack_i && !ill_take) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.CSRSel_o       = id_ex_reg.sel;
  assign bus.ex_csr_valid_o = id_ex_reg.valid;
  assign bus.csr_illegal_o  = (state_reg == ST_PEND);
  assign bus.wb_valid_o     = wb_valid_reg;
  assign bus.wb_rd_o        = wb_rd_reg;
  assign bus.wb_data_o      = wb_data_reg;

endmodule

// File: tb/tb_csr_read_pipe.sv
// Directed bench for csr_read_pipe: expected writebacks go into a queue at
// issue time and a monitor pops them as the stage presents new writebacks.
module tb_csr_read_pipe;
  import csr_read_pipe_pkg::*;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  csr_read_pipe_if bus ();

  csr_read_pipe dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  // Counter unit model: combinational on the select.
  logic [31:0] cnt_tbl [4];
  assign bus.CSR_OUT_i = cnt_tbl[bus.CSRSel_o];

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t  exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic wb_fresh = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr);
    bus.id_valid_i = 1'b1;
    bus.id_instr_i = instr;
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data);
    wb_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // A writeback is new only if the EX/MEM register loaded on the last edge.
  always @(posedge clk_i) wb_fresh <= rst_n_i && !bus.stall_i;

  // Scoreboard monitor.
  always @(negedge clk_i) begin
    wb_t e;
    if (wb_fresh && bus.wb_valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_wb: got write rd=%0d data=0x%08h, expected no write",
                 bus.wb_rd_o, bus.wb_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("wb_rd", 32'(bus.wb_rd_o), 32'(e.rd));
        chk("wb_data", bus.wb_data_o, e.data);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_CSRSel"}, 32'(bus.CSRSel_o), 32'd0);
    chk({tag, "_ex_valid"}, 32'(bus.ex_csr_valid_o), 32'd0);
    chk({tag, "_illegal"}, 32'(bus.csr_illegal_o), 32'd0);
    chk({tag, "_wb_valid"}, 32'(bus.wb_valid_o), 32'd0);
    chk({tag, "_wb_rd"}, 32'(bus.wb_rd_o), 32'd0);
    chk({tag, "_wb_data"}, bus.wb_data_o, 32'd0);
  endtask

  initial begin
    cnt_tbl[0] = 32'h0000_0010;
    cnt_tbl[1] = 32'h1111_0001;
    cnt_tbl[2] = 32'h2222_0002;
    cnt_tbl[3] = 32'h3333_0003;
    bus.stall_i       = 1'b0;
    bus.flush_ID_EX_i = 1'b0;
    bus.id_valid_i    = 1'b0;
    bus.id_instr_i    = 32'h0;
    bus.trap_ack_i    = 1'b0;

    // Reset.
    tick();
    tick();
    chk_reset_outputs("reset");
    rst_n_i = 1'b1;
    tick();

    // rdcycle x6: two-cycle latency, select 0 in EX.
    issue(32'hC000_2373);
    expect_wb(5'd6, 32'h0000_0010);
    tick();
    bus.id_valid_i = 1'b0;
    chk("rdcycle_CSRSel", 32'(bus.CSRSel_o), 32'd0);
    chk("rdcycle_ex_valid", 32'(bus.ex_csr_valid_o), 32'd1);
    tick();
    chk("rdcycle_wb_valid", 32'(bus.wb_valid_o), 32'd1);
    tick();

    // Back-to-back: rdtime x6 (alias of cycle), rdcycleh x7, rdinstret x8.
    issue(32'hC010_2373);
    expect_wb(5'd6, 32'h0000_0010);
    tick();
    chk("rdtime_CSRSel", 32'(bus.CSRSel_o), 32'd0);
    issue(32'hC800_23F3);
    expect_wb(5'd7, 32'h1111_0001);
    tick();
    chk("rdcycleh_CSRSel", 32'(bus.CSRSel_o), 32'd1);
    issue(32'hC020_2473);
    expect_wb(5'd8, 32'h2222_0002);
    tick();
    bus.id_valid_i = 1'b0;
    chk("rdinstret_CSRSel", 32'(bus.CSRSel_o), 32'd2);
    tick();
    tick();

    // rdinstreth x10 stalled three cycles in EX; last unstalled value wins.
    issue(32'hC820_2573);
    tick();
    bus.id_valid_i = 1'b0;
    bus.stall_i    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cnt_tbl[3] = 32'hA000_0000 + 32'(i);
      tick();
      chk("stall_CSRSel", 32'(bus.CSRSel_o), 32'd3);
      chk("stall_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    end
    bus.stall_i = 1'b0;
    cnt_tbl[3]  = 32'h5555_AAAA;
    expect_wb(5'd10, 32'h5555_AAAA);
    tick();
    chk("unstall_wb_valid", 32'(bus.wb_valid_o), 32'd1);
    tick();
    chk("unstall_wb_once", 32'(bus.wb_valid_o), 32'd0);

    // csrrw x1,cycle,x2: write to a mapped counter is illegal.
    issue(32'hC001_10F3);
    tick();
    bus.id_valid_i = 1'b0;
    chk("csrrw_ex_valid", 32'(bus.ex_csr_valid_o), 32'd0);
    chk("csrrw_illegal_in_ex", 32'(bus.csr_illegal_o), 32'd0);
    tick();
    chk("csrrw_illegal_set", 32'(bus.csr_illegal_o), 32'd1);
    tick();
    chk("csrrw_illegal_held", 32'(bus.csr_illegal_o), 32'd1);
    bus.trap_ack_i = 1'b1;
    tick();
    bus.trap_ack_i = 1'b0;
    chk("csrrw_illegal_acked", 32'(bus.csr_illegal_o), 32'd0);
    tick();

    // Two back-to-back mstatus reads; second taken in the ack cycle.
    issue(32'h3000_21F3);
    tick();
    tick();
    chk("mstatus_a_pend", 32'(bus.csr_illegal_o), 32'd1);
    bus.id_valid_i = 1'b0;
    bus.trap_ack_i = 1'b1;
    tick();
    chk("mstatus_b_ack_same_cycle", 32'(bus.csr_illegal_o), 32'd1);
    bus.trap_ack_i = 1'b0;
    tick();
    chk("mstatus_b_held", 32'(bus.csr_illegal_o), 32'd1);
    bus.trap_ack_i = 1'b1;
    tick();
    bus.trap_ack_i = 1'b0;
    chk("mstatus_b_acked", 32'(bus.csr_illegal_o), 32'd0);

    // Flush while stalled squashes the ID/EX contents.
    issue(32'hC000_2373);
    tick();
    chk("preflush_ex_valid", 32'(bus.ex_csr_valid_o), 32'd1);
    issue(32'hC020_2473);
    bus.flush_ID_EX_i = 1'b1;
    bus.stall_i       = 1'b1;
    tick();
    chk("flush_ex_valid", 32'(bus.ex_csr_valid_o), 32'd0);
    bus.flush_ID_EX_i = 1'b0;
    bus.stall_i       = 1'b0;
    bus.id_valid_i    = 1'b0;
    tick();
    tick();

    // rdcycle x0: legal but never written back.
    issue(32'hC000_2073);
    tick();
    bus.id_valid_i = 1'b0;
    chk("x0_ex_valid", 32'(bus.ex_csr_valid_o), 32'd1);
    tick();
    chk("x0_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    tick();

    // Reset mid-stall discards an in-flight read.
    issue(32'hC820_2573);
    tick();
    bus.id_valid_i = 1'b0;
    bus.stall_i    = 1'b1;
    tick();
    chk("prereset_ex_valid", 32'(bus.ex_csr_valid_o), 32'd1);
    rst_n_i = 1'b0;
    tick();
    chk_reset_outputs("midstall_reset");
    rst_n_i     = 1'b1;
    bus.stall_i = 1'b0;
    tick();
    tick();
    chk("postreset_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
